adpll_cfg_seq: RTL and testbench
================================

// Module: adpll_cfg_seq
// PURPOSE
//  Bus initiator for the ADPLL CPU register interface: on a start pulse it programs a channel
//  (soft reset, FCW, mode, enable), polls ADPLL_LOCK until stable lock or timeout, reads ADPLL_SAT,
//  and reports status. Sits between the radio control FSM and adpll_ctr; replaces CPU bring-up code.
// PARAMETERS
//  POLL_GAP      15    idle cycles between consecutive ADPLL_LOCK reads
//  LOCK_TIMEOUT  1024  max ADPLL_LOCK reads before declaring lock_timeout
//  LOCK_CNT      4     consecutive rdata[0]==1 reads required to declare lock
//  ACK_TIMEOUT   8     cycles valid may wait for ready before bus_err
// PORTS
//  clk           in   1                  single clock; bus signals launched on posedge
//  rst           in   1                  synchronous, active-high reset
//  start         in   1                  1-cycle request; ignored while busy
//  fcw           in   `FCWW              channel word (2440 MHz = 'h2620000)
//  mode          in   2                  value written to ADPLL_MODE
//  valid         out  1                  bus request
//  address       out  `ADPLL_ADDR_W      register address (`ADPLL_* / `FCW macros)
//  wdata         out  `ADPLL_DATA_W      write data, zero-extended
//  wstrb         out  1                  1=write, 0=read
//  rdata         in   2                  read data; 2'b11 = unmapped address
//  ready         in   1                  responder ack (responder registers ready<=valid on negedge)
//  busy          out  1                  sequence in progress
//  done          out  1                  1-cycle pulse at sequence end
//  locked        out  1                  LOCK_CNT consecutive lock reads seen
//  lock_timeout  out  1                  LOCK_TIMEOUT reads without lock
//  sat           out  1                  rdata[0] of final ADPLL_SAT read
//  bus_err       out  1                  ack timeout or rdata==2'b11 on a read
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE. rst mid-transaction drops valid the next edge; no completion.
//  - All outputs registered. status (locked/lock_timeout/sat/bus_err) cleared on accepted start,
//    held after done until next start.
//  - Transaction: assert valid/address/wdata/wstrb together, hold stable until ready==1 sampled
//    on posedge (rdata sampled same edge), then deassert valid; next transaction may start only
//    after ready sampled 0 (>=1 idle cycle; no back-to-back valid).
//  - Ack watchdog: counter from valid rise; ready not seen within ACK_TIMEOUT cycles -> drop valid,
//    bus_err=1, go DONE (skip rest).
//  - FSM: IDLE -start-> WR(step) -ack-> GAP -ready==0-> next step ... -> PWAIT -> RD_LOCK -> ...
//    Write steps in order: SOFT_RST=1, SOFT_RST=0, FCW=fcw, ADPLL_MODE=mode, ADPLL_EN=1.
//    PWAIT: count POLL_GAP cycles -> RD_LOCK (wstrb=0, address=`ADPLL_LOCK).
//    RD_LOCK ack: rdata==2'b11 -> bus_err, DONE; rdata[0]=1 -> consec++, else consec=0;
//      poll count++; consec==LOCK_CNT -> locked=1, RD_SAT; polls==LOCK_TIMEOUT -> lock_timeout=1,
//      RD_SAT; else GAP -> PWAIT. Lock on the final allowed poll counts as locked (not timeout).
//    RD_SAT ack: sat=rdata[0] (2'b11 -> bus_err) -> DONE. DONE: done=1 one cycle, busy=0 -> IDLE.
//  - busy=1 from cycle after accepted start until DONE cycle. start while busy: no effect.
//  - Counters saturate/size via $clog2(param+1); no wrap. Minimum latency start->done with
//    immediate lock: 5 writes + LOCK_CNT polls (+gaps) + 1 read.
// STRUCTURE
//  - Register addresses/widths from adpll_defines.vh; state encodings as localparams in this file.
//  - One sub-module: adpll_bus_txn (single transaction engine: valid/ready handshake, idle gap,
//    ack watchdog; returns txn_done, txn_rdata, txn_err). Top holds step/poll FSM and counters.
// TESTING (bench uses real adpll_ctr as responder or a BFM with same negedge ready)
//  1 start, fcw='h2620000, mode=1, BFM lock=1 always -> 5 writes in order, 4 LOCK reads,
//    1 SAT read, done pulse, locked=1, lock_timeout=0, bus_err=0.
//  2 lock pattern 1,1,0,1,1,1,1 -> consec resets on 0; locked after 7th read, exactly 7 LOCK reads.
//  3 LOCK_TIMEOUT=8, lock=0 always -> 8 LOCK reads, SAT read, lock_timeout=1, locked=0.
//  4 BFM never asserts ready on FCW write -> valid drops after ACK_TIMEOUT=8, bus_err=1, done.
//  5 rst asserted during 3rd write -> next cycle valid=0,busy=0, all status 0; restart completes.
//  6 start pulsed while busy and each txn checked: valid stable until ack, >=1 idle cycle between.

Source files
------------

// File: rtl/adpll_cfg_seq_pkg.sv
// Shared widths, register map and state types for the ADPLL configuration sequencer.
package adpll_cfg_seq_pkg;

  localparam int unsigned ADPLL_ADDR_W = 8;
  localparam int unsigned ADPLL_DATA_W = 32;
  localparam int unsigned FCWW         = 28;
  localparam int unsigned NUM_WR_STEPS = 5;

  localparam logic [ADPLL_ADDR_W-1:0] ADDR_SOFT_RST = 8'h00;
  localparam logic [ADPLL_ADDR_W-1:0] ADDR_FCW      = 8'h04;
  localparam logic [ADPLL_ADDR_W-1:0] ADDR_MODE     = 8'h08;
  localparam logic [ADPLL_ADDR_W-1:0] ADDR_EN       = 8'h0c;
  localparam logic [ADPLL_ADDR_W-1:0] ADDR_LOCK     = 8'h10;
  localparam logic [ADPLL_ADDR_W-1:0] ADDR_SAT      = 8'h14;

  typedef enum logic [2:0] {StIdle, StWrite, StPwait, StRdLock, StRdSat, StDone} seq_state_e;
  typedef enum logic [1:0] {TxIdle, TxReq, TxGap} txn_state_e;

  typedef struct packed {
    logic [ADPLL_ADDR_W-1:0] address;
    logic [ADPLL_DATA_W-1:0] wdata;
  } bus_req_t;

  // Programming order: pulse soft reset, then FCW, mode, enable.
  function automatic bus_req_t wr_step(input logic [2:0] step, input logic [FCWW-1:0] fcw,
                                       input logic [1:0] mode);
    bus_req_t r;
    case (step)
      3'd0:    begin r.address = ADDR_SOFT_RST; r.wdata = ADPLL_DATA_W'(1);    end
      3'd1:    begin r.address = ADDR_SOFT_RST; r.wdata = '0;                  end
      3'd2:    begin r.address = ADDR_FCW;      r.wdata = ADPLL_DATA_W'(fcw);  end
      3'd3:    begin r.address = ADDR_MODE;     r.wdata = ADPLL_DATA_W'(mode); end
      default: begin r.address = ADDR_EN;       r.wdata = ADPLL_DATA_W'(1);    end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/adpll_bus_txn.sv
// Single bus transaction engine: valid/ready handshake, ack watchdog and idle gap.
module adpll_bus_txn
  import adpll_cfg_seq_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic [ADPLL_ADDR_W-1:0] req_address,
  input  logic [ADPLL_DATA_W-1:0] req_wdata,
  input  logic                    req_write,
  input  logic                    ready,
  input  logic [1:0]              rdata,
  output logic                    valid,
  output logic [ADPLL_ADDR_W-1:0] address,
  output logic [ADPLL_DATA_W-1:0] wdata,
  output logic                    wstrb,
  output logic                    txn_done,
  output logic                    txn_rdata,
  output logic                    txn_err
);

  localparam int unsigned AckW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AckW-1:0] AckMax = AckW'(ACK_TIMEOUT - 1);

  txn_state_e      state_q;
  logic [AckW-1:0] ack_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TxIdle;
      ack_cnt_q <= '0;
      valid     <= 1'b0;
      address   <= '0;
      wdata     <= '0;
      wstrb     <= 1'b0;
      txn_done  <= 1'b0;
      txn_rdata <= 1'b0;
      txn_err   <= 1'b0;
    end else begin
      txn_done <= 1'b0;
      unique case (state_q)
        TxIdle: begin
          if (req) begin
            valid     <= 1'b1;
            address   <= req_address;
            wdata     <= req_wdata;
            wstrb     <= req_write;
            ack_cnt_q <= '0;
            txn_err   <= 1'b0;
            state_q   <= TxReq;
          end
        end
        TxReq: begin
          if (ready) begin
            valid     <= 1'b0;
            txn_rdata <= rdata[0];
            txn_err   <= !wstrb && (rdata == 2'b11);
            state_q   <= TxGap;
          end else if (ack_cnt_q == AckMax) begin
            valid   <= 1'b0;
            txn_err <= 1'b1;
            state_q <= TxGap;
          end else begin
            ack_cnt_q <= ack_cnt_q + AckW'(1);
          end
        end
        TxGap: begin
          // Completion waits for ready to fall so valid can never go back-to-back.
          if (!ready) begin
            txn_done <= 1'b1;
            state_q  <= TxIdle;
          end
        end
        default: state_q <= TxIdle;
      endcase
    end
  end

endmodule

// File: rtl/adpll_cfg_seq.sv
// ADPLL bring-up sequencer: programs a channel, polls for stable lock, reads saturation.
module adpll_cfg_seq
  import adpll_cfg_seq_pkg::*;
#(
  parameter int unsigned POLL_GAP     = 15,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned LOCK_CNT     = 4,
  parameter int unsigned ACK_TIMEOUT  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [FCWW-1:0]         fcw,
  input  logic [1:0]              mode,
  output logic                    valid,
  output logic [ADPLL_ADDR_W-1:0] address,
  output logic [ADPLL_DATA_W-1:0] wdata,
  output logic                    wstrb,
  input  logic [1:0]              rdata,
  input  logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic                    locked,
  output logic                    lock_timeout,
  output logic                    sat,
  output logic                    bus_err
);

  localparam int unsigned GapW  = $clog2(POLL_GAP + 1);
  localparam int unsigned PollW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned ConsW = $clog2(LOCK_CNT + 1);
  localparam logic [GapW-1:0]  GapMax  = GapW'(POLL_GAP - 1);
  localparam logic [PollW-1:0] PollMax = PollW'(LOCK_TIMEOUT);
  localparam logic [ConsW-1:0] ConsMax = ConsW'(LOCK_CNT);

  seq_state_e              state_q;
  logic [2:0]              step_q;
  logic [FCWW-1:0]         fcw_q;
  logic [1:0]              mode_q;
  logic [GapW-1:0]         gap_q;
  logic [PollW-1:0]        poll_q;
  logic [ConsW-1:0]        cons_q;
  logic                    issue_q;
  logic [ADPLL_ADDR_W-1:0] req_address_q;
  logic [ADPLL_DATA_W-1:0] req_wdata_q;
  logic                    req_write_q;

  logic                    txn_done, txn_rdata, txn_err;
  logic [PollW-1:0]        poll_nxt;
  logic [ConsW-1:0]        cons_nxt;
  bus_req_t                first_req, next_req;

  always_comb begin
    first_req = wr_step(3'd0, fcw, mode);
    next_req  = wr_step(step_q + 3'd1, fcw_q, mode_q);
    poll_nxt  = (poll_q == PollMax) ? poll_q : poll_q + PollW'(1);
    cons_nxt  = '0;
    if (txn_rdata) cons_nxt = (cons_q == ConsMax) ? cons_q : cons_q + ConsW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      step_q        <= '0;
      fcw_q         <= '0;
      mode_q        <= '0;
      gap_q         <= '0;
      poll_q        <= '0;
      cons_q        <= '0;
      issue_q       <= 1'b0;
      req_address_q <= '0;
      req_wdata_q   <= '0;
      req_write_q   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      locked        <= 1'b0;
      lock_timeout  <= 1'b0;
      sat           <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      issue_q <= 1'b0;
      done    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy          <= 1'b1;
            locked        <= 1'b0;
            lock_timeout  <= 1'b0;
            sat           <= 1'b0;
            bus_err       <= 1'b0;
            fcw_q         <= fcw;
            mode_q        <= mode;
            step_q        <= '0;
            issue_q       <= 1'b1;
            req_address_q <= first_req.address;
            req_wdata_q   <= first_req.wdata;
            req_write_q   <= 1'b1;
            state_q       <= StWrite;
          end
        end
        StWrite: begin
          if (txn_done) begin
            if (txn_err) begin
              bus_err <= 1'b1;
              state_q <= StDone;
            end else if (step_q == 3'(NUM_WR_STEPS - 1)) begin
              gap_q   <= '0;
              poll_q  <= '0;
              cons_q  <= '0;
              state_q <= StPwait;
            end else begin
              step_q        <= step_q + 3'd1;
              issue_q       <= 1'b1;
              req_address_q <= next_req.address;
              req_wdata_q   <= next_req.wdata;
              req_write_q   <= 1'b1;
            end
          end
        end
        StPwait: begin
          if (gap_q == GapMax) begin
            issue_q       <= 1'b1;
            req_address_q <= ADDR_LOCK;
            req_wdata_q   <= '0;
            req_write_q   <= 1'b0;
            state_q       <= StRdLock;
          end else begin
            gap_q <= gap_q + GapW'(1);
          end
        end
        StRdLock: begin
          if (txn_done) begin
            if (txn_err) begin
              bus_err <= 1'b1;
              state_q <= StDone;
            end else begin
              cons_q <= cons_nxt;
              poll_q <= poll_nxt;
              // Lock is checked before timeout so a lock on the last poll still counts.
              if (cons_nxt == ConsMax || poll_nxt == PollMax) begin
                locked        <= (cons_nxt == ConsMax);
                lock_timeout  <= (cons_nxt != ConsMax);
                issue_q       <= 1'b1;
                req_address_q <= ADDR_SAT;
                req_wdata_q   <= '0;
                req_write_q   <= 1'b0;
                state_q       <= StRdSat;
              end else begin
                gap_q   <= '0;
                state_q <= StPwait;
              end
            end
          end
        end
        StRdSat: begin
          if (txn_done) begin
            if (txn_err) bus_err <= 1'b1;
            else         sat     <= txn_rdata;
            state_q <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  adpll_bus_txn #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_bus_txn (
    .clk        (clk),
    .rst        (rst),
    .req        (issue_q),
    .req_address(req_address_q),
    .req_wdata  (req_wdata_q),
    .req_write  (req_write_q),
    .ready      (ready),
    .rdata      (rdata),
    .valid      (valid),
    .address    (address),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .txn_done   (txn_done),
    .txn_rdata  (txn_rdata),
    .txn_err    (txn_err)
  );

endmodule

// File: tb/tb_adpll_cfg_seq.sv
// Bench for adpll_cfg_seq: negedge-ready responder, transaction log and sequence model.
module tb_adpll_cfg_seq;
  import adpll_cfg_seq_pkg::*;

  localparam int unsigned POLL_GAP_TB     = 4;
  localparam int unsigned LOCK_TIMEOUT_TB = 8;
  localparam int unsigned LOCK_CNT_TB     = 4;
  localparam int unsigned ACK_TIMEOUT_TB  = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic [FCWW-1:0]         fcw = '0;
  logic [1:0]              mode = '0;
  logic                    valid;
  logic [ADPLL_ADDR_W-1:0] address;
  logic [ADPLL_DATA_W-1:0] wdata;
  logic                    wstrb;
  logic [1:0]              rdata = '0;
  logic                    ready = 1'b0;
  logic                    busy, done, locked, lock_timeout, sat, bus_err;

  adpll_cfg_seq #(
    .POLL_GAP    (POLL_GAP_TB),
    .LOCK_TIMEOUT(LOCK_TIMEOUT_TB),
    .LOCK_CNT    (LOCK_CNT_TB),
    .ACK_TIMEOUT (ACK_TIMEOUT_TB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .fcw         (fcw),
    .mode        (mode),
    .valid       (valid),
    .address     (address),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .rdata       (rdata),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .locked      (locked),
    .lock_timeout(lock_timeout),
    .sat         (sat),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  // Responder scenario, written by the initial block only.
  logic [1:0] lock_pat [16];
  int         lock_len = 0;
  logic [1:0] lock_dflt = 2'b01;
  bit         sat_bit = 1'b0;
  bit         stall_fcw = 1'b0;
  int         run_id = 0;

  // Responder state and logs, written by the responder block only.
  int                      seen_run = 0;
  logic [ADPLL_ADDR_W-1:0] log_a [$];
  logic [ADPLL_DATA_W-1:0] log_d [$];
  bit                      log_w [$];
  int                      lock_idx = 0;
  int                      proto_viol = 0;
  int                      gap_viol = 0;
  int                      stall_cnt = 0;
  int                      idle_run = 100;
  bit                      prev_valid = 1'b0;
  bit                      hold_chk = 1'b0;
  logic [ADPLL_ADDR_W+ADPLL_DATA_W:0] held = '0;

  always @(negedge clk) begin
    bit         grant;
    bit         stalled;
    logic [1:0] rd;
    if (run_id != seen_run) begin
      seen_run = run_id;
      log_a.delete(); log_d.delete(); log_w.delete();
      lock_idx = 0; proto_viol = 0; gap_viol = 0; stall_cnt = 0; idle_run = 100;
    end
    if (valid && ready) proto_viol++;
    if (hold_chk && valid && {address, wdata, wstrb} != held) proto_viol++;
    if (valid && !prev_valid && !wstrb && address == ADDR_LOCK &&
        idle_run < int'(POLL_GAP_TB)) gap_viol++;
    idle_run = valid ? 0 : idle_run + 1;
    stalled = stall_fcw && wstrb && address == ADDR_FCW;
    if (valid && stalled) stall_cnt++;
    grant = valid && !ready && !stalled;
    rd = 2'b00;
    if (grant) begin
      log_a.push_back(address); log_d.push_back(wdata); log_w.push_back(wstrb);
      if (!wstrb && address == ADDR_LOCK) begin
        rd = (lock_idx < lock_len) ? lock_pat[lock_idx] : lock_dflt;
        lock_idx++;
      end else if (!wstrb && address == ADDR_SAT) begin
        rd = {1'b0, sat_bit};
      end
    end
    held = {address, wdata, wstrb};
    hold_chk = valid && !grant;
    prev_valid = valid;
    ready = grant;
    rdata = rd;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Expected transaction list and status, derived from the sequence rules.
  logic [ADPLL_ADDR_W-1:0] exp_a [$];
  logic [ADPLL_DATA_W-1:0] exp_d [$];
  bit                      exp_w [$];
  bit e_locked, e_to, e_sat, e_err;

  task automatic push_exp(input logic [ADPLL_ADDR_W-1:0] a, input logic [31:0] d, input bit w);
    exp_a.push_back(a); exp_d.push_back(d); exp_w.push_back(w);
  endtask

  task automatic build_exp(input logic [FCWW-1:0] f, input logic [1:0] m, input bit stall);
    int         consec;
    logic [1:0] v;
    exp_a.delete(); exp_d.delete(); exp_w.delete();
    e_locked = 0; e_to = 0; e_sat = 0; e_err = 0;
    push_exp(ADDR_SOFT_RST, 32'd1, 1'b1);
    push_exp(ADDR_SOFT_RST, 32'd0, 1'b1);
    if (stall) begin
      e_err = 1;
      return;
    end
    push_exp(ADDR_FCW, 32'(f), 1'b1);
    push_exp(ADDR_MODE, 32'(m), 1'b1);
    push_exp(ADDR_EN, 32'd1, 1'b1);
    consec = 0;
    for (int p = 0; p < int'(LOCK_TIMEOUT_TB); p++) begin
      v = (p < lock_len) ? lock_pat[p] : lock_dflt;
      push_exp(ADDR_LOCK, 32'd0, 1'b0);
      if (v == 2'b11) begin
        e_err = 1;
        return;
      end
      consec = v[0] ? consec + 1 : 0;
      if (consec == int'(LOCK_CNT_TB)) begin
        e_locked = 1;
        break;
      end
      if (p == int'(LOCK_TIMEOUT_TB) - 1) e_to = 1;
    end
    push_exp(ADDR_SAT, 32'd0, 1'b0);
    e_sat = sat_bit;
  endtask

  task automatic run_seq(input string tag, input logic [FCWW-1:0] f, input logic [1:0] m,
                         input bit stall, input bit pulse_busy);
    bit got;
    int n;
    stall_fcw = stall;
    build_exp(f, m, stall);
    run_id++;
    @(negedge clk);
    @(posedge clk); #1;
    fcw = f; mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    got = 0;
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        got = 1;
        break;
      end
      if (pulse_busy && busy && (k % 7 == 3)) begin
        start = 1'b1; fcw = FCWW'($urandom); mode = 2'($urandom);
      end
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_locked"}, 64'(locked), 64'(e_locked));
    check({tag, "_lock_timeout"}, 64'(lock_timeout), 64'(e_to));
    check({tag, "_sat"}, 64'(sat), 64'(e_sat));
    check({tag, "_bus_err"}, 64'(bus_err), 64'(e_err));
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    check({tag, "_status_held"}, 64'({locked, lock_timeout, sat, bus_err}),
          64'({e_locked, e_to, e_sat, e_err}));
    check({tag, "_txn_count"}, 64'(log_a.size()), 64'(exp_a.size()));
    n = (log_a.size() < exp_a.size()) ? log_a.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(log_a[i]), 64'(exp_a[i]));
      check($sformatf("%s_wstrb%0d", tag, i), 64'(log_w[i]), 64'(exp_w[i]));
      if (exp_w[i]) check($sformatf("%s_wdata%0d", tag, i), 64'(log_d[i]), 64'(exp_d[i]));
    end
    check({tag, "_handshake_rules"}, 64'(proto_viol), 64'd0);
    check({tag, "_poll_gap"}, 64'(gap_viol), 64'd0);
  endtask

  task automatic set_pat(input int len, input logic [15:0][1:0] p, input logic [1:0] dflt);
    lock_len = len;
    for (int i = 0; i < 16; i++) lock_pat[i] = p[i];
    lock_dflt = dflt;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    logic [15:0][1:0] p;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({valid, wstrb, busy, done, locked, lock_timeout, sat, bus_err}),
          64'd0);
    check("reset_addr_wdata", 64'({address, wdata}), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Always locked: minimum sequence.
    p = '0; set_pat(0, p, 2'b01); sat_bit = 1'b1;
    run_seq("t1", FCWW'(28'h2620000), 2'd1, 1'b0, 1'b0);

    // Lock broken by a zero read: needs seven reads.
    p = '0;
    p[0] = 2'b01; p[1] = 2'b01; p[2] = 2'b00; p[3] = 2'b01;
    p[4] = 2'b01; p[5] = 2'b01; p[6] = 2'b01;
    set_pat(7, p, 2'b00); sat_bit = 1'b0;
    run_seq("t2", FCWW'($urandom), 2'($urandom), 1'b0, 1'b0);

    // Never locks: timeout after LOCK_TIMEOUT reads.
    p = '0; set_pat(0, p, 2'b00); sat_bit = 1'b1;
    run_seq("t3", FCWW'($urandom), 2'($urandom), 1'b0, 1'b0);

    // Lock completes exactly on the last permitted poll.
    p = '0;
    p[4] = 2'b01; p[5] = 2'b01; p[6] = 2'b01; p[7] = 2'b01;
    set_pat(8, p, 2'b00); sat_bit = 1'b0;
    run_seq("t3b", FCWW'($urandom), 2'($urandom), 1'b0, 1'b0);

    // Responder never acks the FCW write.
    p = '0; set_pat(0, p, 2'b01);
    run_seq("t4", FCWW'($urandom), 2'($urandom), 1'b1, 1'b0);
    check("t4_valid_hold_cycles", 64'(stall_cnt), 64'(ACK_TIMEOUT_TB));
    stall_fcw = 1'b0;

    // Unmapped response on a lock read.
    p = '0; p[0] = 2'b01; p[1] = 2'b11; set_pat(2, p, 2'b01);
    run_seq("t4b", FCWW'($urandom), 2'($urandom), 1'b0, 1'b0);

    // Reset in the middle of the third write.
    p = '0; set_pat(0, p, 2'b01);
    run_id++;
    @(negedge clk);
    @(posedge clk); #1;
    fcw = FCWW'($urandom); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 0;
    for (int k = 0; k < 200; k++) begin
      if (valid && wstrb && address == ADDR_FCW) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("t5_reached_third_write", 64'(got), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_after_rst", 64'({valid, busy, done, locked, lock_timeout, sat, bus_err}), 64'd0);
    repeat (3) @(posedge clk);
    sat_bit = 1'b1;
    run_seq("t5_restart", FCWW'($urandom), 2'($urandom), 1'b0, 1'b0);

    // Start pulses while busy must be ignored.
    p = '0; p[0] = 2'b01; p[1] = 2'b00; set_pat(2, p, 2'b01); sat_bit = 1'b0;
    run_seq("t6", FCWW'($urandom), 2'($urandom), 1'b0, 1'b1);

    // Random lock patterns.
    for (int r = 0; r < 6; r++) begin
      p = '0;
      for (int i = 0; i < 16; i++) p[i] = ($urandom_range(0, 3) != 0) ? 2'b01 : 2'b00;
      set_pat(int'($urandom_range(0, 10)), p, 2'($urandom_range(0, 1)));
      sat_bit = 1'($urandom);
      run_seq($sformatf("rnd%0d", r), FCWW'($urandom), 2'($urandom), 1'b0, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
